adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
- Sits directly downstream of the AD9643 LVDS input buffers. Consumes the buffered single-ended sample bus in the ADC clock domain.
- Optionally converts offset-binary samples to two's complement.
- Waits for a software arm plus a trigger condition, then captures a programmable-length block into internal RAM.
- Drains the block over a valid/ready stream with a last-sample marker.

Parameters:
- DATA_WIDTH, 14: ADC sample width in bits.
- DEPTH_LOG2, 10: log2 of capture buffer depth, so the maximum block is 2^DEPTH_LOG2 samples.
- OFFSET_BIN, 1: 1 inverts the sample MSB (offset binary to two's complement); 0 passes the sample through.

Ports:
- clk, input, 1: ADC sample clock, from the LVDS clock buffer output. Sole clock.
- rst_n, input, 1: asynchronous, active-low reset.
- adc_data, input, DATA_WIDTH: buffered ADC sample, valid every clk.
- arm, input, 1: single-cycle request to start a capture.
- abort, input, 1: synchronous cancel.
- trig_mode, input, 1: 0 means trigger immediately; 1 means trigger on a rising threshold crossing.
- threshold, input, DATA_WIDTH: signed two's-complement trigger level.
- capture_len, input, DEPTH_LOG2+1: number of samples to capture. Latched on accepted arm.
- m_tdata, output, DATA_WIDTH: drained sample.
- m_tvalid, output, 1: m_tdata is valid.
- m_tready, input, 1: downstream accepts the current beat.
- m_tlast, output, 1: marks the final sample of the block.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when a drain completes.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, done=0; write/read pointers=0; sample registers=0. RAM contents are don't-care.
- Input stage, every cycle:
  - s0 <= adc_data with the MSB inverted if OFFSET_BIN=1.
  - s1 <= s0.
  - All comparisons are signed on DATA_WIDTH bits.
- IDLE:
  - arm=1 latches len = capture_len; a value of 0 is treated as 2^DEPTH_LOG2, and values above 2^DEPTH_LOG2 saturate to 2^DEPTH_LOG2.
  - Clears wr_ptr and moves to ARMED.
  - arm in any other state is ignored.
- ARMED:
  - Trigger fires when trig_mode=0, or when (s1 < threshold) and (s0 >= threshold).
  - s1 is invalid on the first ARMED cycle, so level-only crossings are not accepted on that cycle.
  - On trigger: write s0 at address 0, set wr_ptr=1, go to CAPTURE; if len=1, go directly to DRAIN.
- CAPTURE:
  - Write s0 at wr_ptr every cycle and increment wr_ptr.
  - The sample written at wr_ptr = len-1 is the last; the next state is DRAIN.
  - Samples are contiguous: no gaps and no duplicates.
- DRAIN:
  - RAM read is synchronous with 1-cycle latency; the read address is prefetched so m_tvalid rises at most 2 cycles after DRAIN entry.
  - m_tdata/m_tlast are held stable while m_tvalid=1 and m_tready=0.
  - A beat transfers when m_tvalid and m_tready are both 1.
  - m_tlast=1 only on beat index len-1.
  - Full throughput with m_tready held high: one beat per cycle.
  - After the last beat: m_tvalid=0, done=1 for one cycle, state=IDLE.
- Block ordering: the first drained sample is the trigger sample; order follows capture order.
- abort=1, in any state:
  - Next state is IDLE; m_tvalid=0 and m_tlast=0 on the next cycle; done is not pulsed.
  - abort has priority over arm, trigger and a beat transfer in the same cycle.
  - A partially drained block is discarded.
- arm and abort asserted together in IDLE: abort wins and the state stays IDLE.
- threshold and trig_mode are sampled live during ARMED only.
- busy = (state != IDLE), registered.
- rst_n asserted mid-CAPTURE or mid-DRAIN: all outputs return to reset values immediately, asynchronously.

Test Plan:
- Immediate trigger: OFFSET_BIN=1, trig_mode=0, capture_len=8, adc_data ramp 0x2000,0x2001,... → stream beats 0x0000..0x0007 (MSB inverted), m_tlast on beat 7, done pulses once, busy falls.
- Threshold trigger: trig_mode=1, threshold=100, signed input 90,95,99,100,120 → first captured sample is 100; a steady input ≥100 at arm produces no trigger until it drops below 100 and then rises.
- Backpressure: capture_len=16, m_tready toggled 1,0,0,1 pseudo-randomly → exactly 16 beats in order, m_tdata stable while stalled, m_tlast only on the 16th.
- Length edges: capture_len=1 → single beat with m_tlast=1; capture_len=0 and capture_len=2^DEPTH_LOG2+5 → 2^DEPTH_LOG2 beats each.
- Abort: abort at drain beat 3 of 8 → m_tvalid low next cycle, no done, busy low; a following arm captures a fresh, correct block.
- Async reset mid-CAPTURE: rst_n low for 1 ns between edges → outputs zero immediately; after release, arm+trigger works normally and arm during ARMED is ignored.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// Triggered block capture of AD9643 samples into internal RAM, drained over a
// valid/ready stream with a last-sample marker.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | waiting for arm; outputs quiet
// ARMED   | length latched, watching for the trigger condition
// CAPTURE | writing one sample per cycle until len samples are stored
// DRAIN   | streaming the stored block out, first sample = trigger sample
module adc_capture_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH_LOG2 = 10,
    parameter int OFFSET_BIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig_mode,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic [DEPTH_LOG2:0]   capture_len,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEN_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MSB_FLIP =
        (OFFSET_BIN != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   s0_q, s0_d, s1_q;
    logic [DEPTH_LOG2:0]     len_q, len_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_idx_q, rd_idx_d;
    logic                    first_q, first_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    done_q, done_d;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    we;
    logic [DEPTH_LOG2-1:0]   waddr;
    logic                    trig;
    logic                    beat;
    logic                    last_beat;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign s0_d = adc_data ^ MSB_FLIP;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        rd_idx_d  = rd_idx_q;
        first_d   = 1'b0;
        tvalid_d  = tvalid_q;
        done_d    = 1'b0;
        we        = 1'b0;
        waddr     = wr_ptr_q;
        // s1 holds a pre-arm sample on the first ARMED cycle, so no crossing there
        trig      = !trig_mode ||
                    (!first_q && ($signed(s1_q) < $signed(threshold)) &&
                     ($signed(s0_q) >= $signed(threshold)));
        beat      = tvalid_q && m_tready;
        last_beat = ({1'b0, rd_idx_q} == (len_q - 1'b1));

        case (state_q)
            IDLE: begin
                if (arm) begin
                    len_d    = ((capture_len == '0) || (capture_len > LEN_MAX)) ?
                               LEN_MAX : capture_len;
                    wr_ptr_d = '0;
                    rd_idx_d = '0;
                    first_d  = 1'b1;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (trig) begin
                    we       = 1'b1;
                    waddr    = '0;
                    wr_ptr_d = PTR_ONE;
                    rd_idx_d = '0;
                    state_d  = (len_q == 1) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                we       = 1'b1;
                waddr    = wr_ptr_q;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if ({1'b0, wr_ptr_q} == (len_q - 1'b1)) begin
                    rd_idx_d = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                // first DRAIN cycle prefetches address 0; valid rises on the next edge
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                end else if (beat) begin
                    if (last_beat) begin
                        tvalid_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            done_d   = 1'b0;
            first_d  = 1'b0;
            we       = 1'b0;
        end

        tlast_d = tvalid_d && ({1'b0, rd_idx_d} == (len_q - 1'b1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s0_q      <= '0;
            s1_q      <= '0;
            len_q     <= '0;
            wr_ptr_q  <= '0;
            rd_idx_q  <= '0;
            first_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            s0_q      <= s0_d;
            s1_q      <= s0_q;
            len_q     <= len_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_idx_q  <= rd_idx_d;
            first_q   <= first_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            done_q    <= done_d;
            busy_q    <= (state_d != IDLE);
            if (state_q == DRAIN) begin
                rd_data_q <= mem[rd_idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= s0_q;
        end
    end

    assign m_tdata  = rd_data_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench for adc_capture_ctrl: every driven sample is logged, and the
// expected block is located in that log from the arm/trigger rules.
`timescale 1ns/1ps

module tb_adc_capture_ctrl;

    localparam int DW    = 14;
    localparam int DL    = 10;
    localparam int DEPTH = 1024;
    localparam int HN    = 16384;
    localparam logic [DW-1:0] MSB = 14'h2000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trig_mode = 1'b0;
    logic [DW-1:0] threshold = '0;
    logic [DL:0]   capture_len = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          busy;
    logic          done;

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    logic [DW-1:0] hist [HN];
    int            dmode = 1;
    logic [DW-1:0] ramp_v = '0;
    int            seq[$];
    int            fv;

    adc_capture_ctrl #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .OFFSET_BIN(1)) dut (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .threshold(threshold), .capture_len(capture_len),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    // log of the converted sample present at each rising edge
    always @(posedge clk) begin
        hist[cyc % HN] <= adc_data ^ MSB;
        cyc <= cyc + 1;
    end

    initial forever begin
        @(negedge clk);
        #1;
        case (dmode)
            0: begin adc_data = ramp_v; ramp_v = ramp_v + 1'b1; end
            1: adc_data = DW'($urandom);
            default: if (seq.size() > 0) adc_data = DW'(seq.pop_front()) ^ MSB;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic int sv(input logic [DW-1:0] x);
        return int'($signed(x));
    endfunction

    // index in hist of the first captured sample, given the arm edge
    function automatic int find_start(input int a, input bit mode, input int thr);
        if (!mode) return a;
        for (int k = a + 2; k < a + 3000; k++)
            if (sv(hist[(k-2) % HN]) < thr && sv(hist[(k-1) % HN]) >= thr) return k - 1;
        return -1;
    endfunction

    task automatic sync2();
        @(negedge clk);
        #2;
    endtask

    task automatic run_block(input int cl, input bit mode, input int thr, input bit rand_rdy,
                             input int abort_at, input int rearm_len, output int first_val);
        int len, a, s, w, beat;
        len = (cl == 0 || cl > DEPTH) ? DEPTH : cl;
        first_val = -1;
        @(negedge clk);
        trig_mode = mode; threshold = DW'(thr); capture_len = (DL+1)'(cl); arm = 1'b1; m_tready = 1'b0;
        @(posedge clk);
        a = cyc;
        @(negedge clk);
        arm = 1'b0;
        check("busy_armed", busy, 1);
        w = 0;
        while (!m_tvalid && w < 3000) begin
            if (rearm_len >= 0 && w == 0) begin arm = 1'b1; capture_len = (DL+1)'(rearm_len); end
            else arm = 1'b0;
            @(negedge clk);
            w++;
        end
        arm = 1'b0;
        if (!m_tvalid) begin check("valid_timeout", m_tvalid, 1); return; end
        s = find_start(a, mode, thr);
        if (s < 0) begin check("trigger_found", 0, 1); return; end
        first_val = sv(hist[s % HN]);
        beat = 0;
        for (int c = 0; c < 4 * len + 20; c++) begin
            check("tvalid", m_tvalid, 1);
            check("tdata", m_tdata, hist[(s + beat) % HN]);
            check("tlast", m_tlast, (beat == len - 1) ? 1 : 0);
            check("no_done", done, 0);
            if (beat == abort_at) begin
                abort = 1'b1; m_tready = 1'b1;
                @(negedge clk);
                abort = 1'b0; m_tready = 1'b0;
                check("abort_tvalid", m_tvalid, 0);
                check("abort_tlast", m_tlast, 0);
                check("abort_done", done, 0);
                check("abort_busy", busy, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_quiet", {done, m_tvalid}, 0);
                end
                return;
            end
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_tready) beat++;
            @(negedge clk);
            if (beat == len) begin
                m_tready = 1'b0;
                check("end_tvalid", m_tvalid, 0);
                check("end_done", done, 1);
                check("end_busy", busy, 0);
                check("end_tlast", m_tlast, 0);
                @(negedge clk);
                check("done_pulse", done, 0);
                return;
            end
        end
        check("drain_timeout", beat, len);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tdata", m_tdata, 0);
        rst_n = 1'b1;

        sync2(); dmode = 0; ramp_v = 14'h2000;
        run_block(8, 0, 0, 0, -1, -1, fv);
        check("ramp_first", fv, 0);

        sync2(); dmode = 2; seq = {90, 95, 99, 100, 120};
        run_block(8, 1, 100, 0, -1, -1, fv);
        check("thr_first", fv, 100);

        sync2(); dmode = 2; seq = {0};
        sync2(); seq = {150, 150, 150, 50, 150, 160, 170};
        run_block(4, 1, 100, 0, -1, -1, fv);
        check("thr_steady_first", fv, 150);

        sync2(); dmode = 1;
        run_block(16, 0, 0, 1, -1, -1, fv);
        for (int i = 0; i < 3; i++) run_block($urandom_range(2, 40), 0, 0, 1, -1, -1, fv);

        run_block(1, 0, 0, 0, -1, -1, fv);
        run_block(0, 0, 0, 0, -1, -1, fv);
        run_block(DEPTH + 5, 0, 0, 1, -1, -1, fv);

        @(negedge clk); arm = 1'b1; abort = 1'b1; capture_len = 11'd8;
        @(negedge clk); arm = 1'b0; abort = 1'b0;
        check("arm_abort_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            check("arm_abort_idle", {busy, m_tvalid}, 0);
        end

        run_block(8, 0, 0, 0, 3, -1, fv);
        run_block(8, 0, 0, 1, -1, -1, fv);

        @(negedge clk); capture_len = 11'd64; trig_mode = 1'b0; arm = 1'b1;
        @(negedge clk); arm = 1'b0;
        check("cap_busy", busy, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_tdata", m_tdata, 0);
        check("arst_flags", {m_tvalid, m_tlast, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle", busy, 0);

        sync2(); dmode = 2; seq = {-50, -50, -50, -50, -50, -50, 200, 210, 220};
        run_block(8, 1, 0, 0, -1, 3, fv);
        check("post_rst_first", fv, 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
